bcd_upcounter_6digit: RTL and testbench
=======================================

BCD_UPCOUNTER_6DIGIT -- requirements
Module: bcd_upcounter_6digit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port list (name direction width meaning) SHALL be:
- clk input 1 — system clock, rising edge.
- rst_n input 1 — asynchronous active-low reset.
- tick input 1 — count-advance pulse, sampled each cycle.
- start_stop input 1 — single-cycle pulse; toggles RUN/STOP state.
- load input 1 — synchronous load of init digits.
- init5..init0 input 4 each — BCD load values, digit 5 = most significant.
- limit5..limit0 input 4 each — per-digit wrap value, BCD.
- value5..value0 output 4 each — current BCD digits.
- running output 1 — 1 while in RUN.
- carry_out output 1 — combinational; high when a counting step occurs with all digits at their limits.
- overflow output 1 — sticky flag, set on full-chain wrap.

Function
REQ-003 The control FSM SHALL have two states, STOP and RUN; a start_stop pulse SHALL toggle the state on the next edge.
REQ-004 Effective enable SHALL be inc = running & tick; when inc is low, digits SHALL hold.
REQ-005 Digit 0 SHALL step when inc is high; digit i (i = 1..5) SHALL step when inc is high and digits 0..i-1 are all at their limits (ripple carry, same cycle).
REQ-006 A stepping digit SHALL go from value to value+1 if value < limit; otherwise it SHALL go to 0 and propagate carry.
REQ-007 A limit above 9 SHALL be treated as 9.
REQ-008 An init value above its effective limit SHALL load as given; its next step SHALL wrap it to 0 with carry.
REQ-009 Latency: digits SHALL update on the clock edge following the cycle in which inc is sampled high.
REQ-010 carry_out SHALL equal inc AND (every digit at its effective limit).
REQ-011 overflow SHALL set on the edge where carry_out is high, and SHALL stay set until load or reset.
REQ-012 On load, all digits SHALL take init5..init0, overflow SHALL clear, and the FSM SHALL go to STOP.
REQ-013 Load SHALL override inc and start_stop in the same cycle.
REQ-014 When start_stop and tick are high in the same cycle, that cycle's inc SHALL use the pre-toggle running value.
REQ-015 A limit change while running SHALL take effect on the next step; no other correction is applied.

Reset
REQ-016 Asserting rst_n low SHALL immediately force the following, independent of clk: all value digits to 0, running to 0 (STOP), and overflow to 0.
REQ-017 Reset asserted mid-count SHALL abandon the count; there is no resume.
REQ-018 After rst_n deasserts, the block SHALL take its first action on the next rising clk edge.

Configuration
REQ-019 Macro BCD_UPCNT_SATURATE_EN SHALL select full-chain behaviour.
REQ-020 With BCD_UPCNT_SATURATE_EN defined, a step with all digits at their limits SHALL hold every digit at its limit, set overflow, and force STOP.
REQ-021 Without BCD_UPCNT_SATURATE_EN, a step with all digits at their limits SHALL wrap every digit to 0, set overflow, and remain in RUN.

Verification
REQ-022 Reset and load check: reset, then load with init = 00:00:00 and limits 9,9,5,9,5,9 -> values 0, running 0, overflow 0.
REQ-023 Single carry: from value0 = 9, limit0 = 9, RUN, one tick -> value0 = 0 and value1 increments by 1 on the same edge.
REQ-024 Wrap with macro undefined: init = 9,9,5,9,5,9 equal to limits, RUN, one tick -> all digits 0, carry_out pulses high one cycle, overflow = 1, running stays 1.
REQ-025 Saturate with macro defined: same stimulus as REQ-024 -> digits hold 9,9,5,9,5,9, overflow = 1, running = 0.
REQ-026 Priority: load, start_stop and tick all high in one cycle with init = 1,2,3,4,5,6 -> values 1,2,3,4,5,6, running 0, no increment.
REQ-027 Asynchronous reset: assert rst_n low between clock edges while RUN at 0,0,0,1,2,3 -> outputs go to 0 before the next edge.

Source files
------------

// File: rtl/bcd_upcounter_6digit.sv
// bcd_upcounter_6digit: six-digit BCD up-counter with per-digit wrap limits,
// RUN/STOP control, combinational full-chain carry and sticky overflow.
// Optional build macro BCD_UPCNT_SATURATE_EN: a full-chain step holds every
// digit at its limit and forces STOP instead of wrapping to zero.
//
// state | meaning
// STOP  | digits hold regardless of tick
// RUN   | digits step on every cycle with tick high
module bcd_upcounter_6digit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       load,
   input  logic [3:0] init5,
   input  logic [3:0] init4,
   input  logic [3:0] init3,
   input  logic [3:0] init2,
   input  logic [3:0] init1,
   input  logic [3:0] init0,
   input  logic [3:0] limit5,
   input  logic [3:0] limit4,
   input  logic [3:0] limit3,
   input  logic [3:0] limit2,
   input  logic [3:0] limit1,
   input  logic [3:0] limit0,
   output logic [3:0] value5,
   output logic [3:0] value4,
   output logic [3:0] value3,
   output logic [3:0] value2,
   output logic [3:0] value1,
   output logic [3:0] value0,
   output logic       running,
   output logic       carry_out,
   output logic       overflow
);

   localparam logic STOP = 1'b0;
   localparam logic RUN  = 1'b1;

   logic [5:0][3:0] init_w;
   logic [5:0][3:0] lim_w;
   logic [5:0][3:0] lim_eff;
   logic [5:0][3:0] val_q, val_d;
   logic [5:0]      at_lim;
   logic [5:0]      step_en;
   logic            state_q, state_d;
   logic            ovf_q, ovf_d;
   logic            inc;
   logic            full_carry;
   logic            chain;

   assign init_w = {init5, init4, init3, init2, init1, init0};
   assign lim_w  = {limit5, limit4, limit3, limit2, limit1, limit0};

   assign {value5, value4, value3, value2, value1, value0} = val_q;
   assign running  = (state_q == RUN);
   assign overflow = ovf_q;

   // Clamp limits to 9; a digit loaded above its limit counts as "at limit"
   // so its next step wraps with carry.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         lim_eff[i] = (lim_w[i] > 4'd9) ? 4'd9 : lim_w[i];
         at_lim[i]  = (val_q[i] >= lim_eff[i]);
      end
   end

   assign inc        = running & tick;
   assign full_carry = inc & (&at_lim);
   assign carry_out  = full_carry;

   // Same-cycle ripple: a digit steps when every lower digit sits at its limit.
   always_comb begin
      chain = inc;
      step_en = '0;
      for (int i = 0; i < 6; i++) begin
         step_en[i] = chain;
         chain      = chain & at_lim[i];
      end
   end

   // Digit next-state; load has absolute priority.
   always_comb begin
      val_d = val_q;
      for (int i = 0; i < 6; i++) begin
         if (load) begin
            val_d[i] = init_w[i];
         end else if (step_en[i]) begin
`ifdef BCD_UPCNT_SATURATE_EN
            if (full_carry)
               val_d[i] = lim_eff[i];
            else if (at_lim[i])
               val_d[i] = 4'd0;
            else
               val_d[i] = val_q[i] + 4'd1;
`else
            if (at_lim[i])
               val_d[i] = 4'd0;
            else
               val_d[i] = val_q[i] + 4'd1;
`endif
         end
      end
   end

   // Control FSM and sticky overflow next-state.
   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      if (load) begin
         state_d = STOP;
         ovf_d   = 1'b0;
      end else begin
         if (full_carry)
            ovf_d = 1'b1;
`ifdef BCD_UPCNT_SATURATE_EN
         if (full_carry)
            state_d = STOP;
         else if (start_stop)
            state_d = ~state_q;
`else
         if (start_stop)
            state_d = ~state_q;
`endif
      end
   end

   // State registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q   <= '0;
         state_q <= STOP;
         ovf_q   <= 1'b0;
      end else begin
         val_q   <= val_d;
         state_q <= state_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_bcd_upcounter_6digit.sv
// Testbench for bcd_upcounter_6digit: directed scenarios plus a randomized
// run checked by a queue-based scoreboard against a digit-array model.
module tb_bcd_upcounter_6digit;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       start_stop;
   logic       load;
   logic [3:0] init_v [6];
   logic [3:0] lim_v  [6];
   logic [3:0] value5, value4, value3, value2, value1, value0;
   logic       running, carry_out, overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        co;
      logic [23:0] val;
      logic        run;
      logic        ovf;
   } exp_t;

   exp_t exp_q [$];

   // reference model state
   int m_val [6];
   bit m_run;
   bit m_ovf;

   bcd_upcounter_6digit dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .load(load),
      .init5(init_v[5]), .init4(init_v[4]), .init3(init_v[3]),
      .init2(init_v[2]), .init1(init_v[1]), .init0(init_v[0]),
      .limit5(lim_v[5]), .limit4(lim_v[4]), .limit3(lim_v[3]),
      .limit2(lim_v[2]), .limit1(lim_v[1]), .limit0(lim_v[0]),
      .value5(value5), .value4(value4), .value3(value3),
      .value2(value2), .value1(value1), .value0(value0),
      .running(running), .carry_out(carry_out), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] dut_val();
      return {value5, value4, value3, value2, value1, value0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic set_digits(output logic [3:0] d [6], input logic [23:0] packed_v);
      for (int i = 0; i < 6; i++) d[i] = packed_v[i*4 +: 4];
   endtask

   // One directed cycle: drive at negedge, sample carry mid-low-phase,
   // return after the rising edge settles.
   task automatic cyc(input logic t, input logic s, input logic l, output logic co_mid);
      @(negedge clk);
      tick = t; start_stop = s; load = l;
      #2 co_mid = carry_out;
      @(posedge clk);
      #1;
   endtask

   function automatic int eff(input int lim);
      return (lim > 9) ? 9 : lim;
   endfunction

   // Model one clock: returns the carry_out expected during this cycle and
   // advances the model to the post-edge state.
   function automatic bit model_step(input bit t, input bit s, input bit l);
      bit inc, all_at, co;
      int k;
      inc = m_run && t;
      all_at = 1;
      for (int i = 0; i < 6; i++)
         if (m_val[i] < eff(int'(lim_v[i]))) all_at = 0;
      co = inc && all_at;
      if (l) begin
         for (int i = 0; i < 6; i++) m_val[i] = int'(init_v[i]);
         m_ovf = 0;
         m_run = 0;
      end else begin
         if (inc) begin
            if (all_at) begin
`ifdef BCD_UPCNT_SATURATE_EN
               for (int i = 0; i < 6; i++) m_val[i] = eff(int'(lim_v[i]));
`else
               for (int i = 0; i < 6; i++) m_val[i] = 0;
`endif
            end else begin
               k = 0;
               while (m_val[k] >= eff(int'(lim_v[k]))) k++;
               m_val[k] = m_val[k] + 1;
               for (int i = 0; i < k; i++) m_val[i] = 0;
            end
         end
         if (co) m_ovf = 1;
`ifdef BCD_UPCNT_SATURATE_EN
         if (co) m_run = 0;
         else if (s) m_run = !m_run;
`else
         if (s) m_run = !m_run;
`endif
      end
      return co;
   endfunction

   function automatic logic [23:0] model_val();
      logic [23:0] v;
      for (int i = 0; i < 6; i++) v[i*4 +: 4] = m_val[i][3:0];
      return v;
   endfunction

   // Scoreboard monitor: pops one expectation per cycle when present.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_carry_out", {31'd0, carry_out}, {31'd0, e.co});
            @(posedge clk);
            #1;
            chk("sb_values", {8'd0, dut_val()}, {8'd0, e.val});
            chk("sb_running", {31'd0, running}, {31'd0, e.run});
            chk("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
         end
      end
   end

   initial begin : main
      logic co;
      exp_t e;
      bit t, s, l;
      int waited;

      rst_n = 1'b0; tick = 0; start_stop = 0; load = 0;
      set_digits(init_v, 24'h000000);
      set_digits(lim_v, 24'h995959);
      #3;
      chk("reset_values", {8'd0, dut_val()}, 32'd0);
      chk("reset_running", {31'd0, running}, 32'd0);
      chk("reset_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset and load check
      cyc(0, 0, 1, co);
      chk("load0_values", {8'd0, dut_val()}, 32'd0);
      chk("load0_running", {31'd0, running}, 32'd0);
      chk("load0_overflow", {31'd0, overflow}, 32'd0);

      // single carry from digit 0 into digit 1
      set_digits(init_v, 24'h000009);
      cyc(0, 0, 1, co);
      cyc(0, 1, 0, co);
      chk("start_running", {31'd0, running}, 32'd1);
      cyc(1, 0, 0, co);
      chk("single_carry_co", {31'd0, co}, 32'd0);
      chk("single_carry_values", {8'd0, dut_val()}, 32'h000010);

      // full-chain step with all digits at their limits
      set_digits(init_v, 24'h995959);
      cyc(0, 0, 1, co);
      cyc(0, 1, 0, co);
      cyc(1, 0, 0, co);
      chk("chain_carry_out_high", {31'd0, co}, 32'd1);
`ifdef BCD_UPCNT_SATURATE_EN
      chk("chain_values", {8'd0, dut_val()}, 32'h995959);
      chk("chain_running", {31'd0, running}, 32'd0);
`else
      chk("chain_values", {8'd0, dut_val()}, 32'h000000);
      chk("chain_running", {31'd0, running}, 32'd1);
`endif
      chk("chain_overflow", {31'd0, overflow}, 32'd1);
      cyc(0, 0, 0, co);
      chk("chain_carry_out_pulse", {31'd0, co}, 32'd0);
      chk("chain_overflow_sticky", {31'd0, overflow}, 32'd1);

      // load beats start_stop and tick in the same cycle
      if (!running) cyc(0, 1, 0, co);
      set_digits(init_v, 24'h123456);
      cyc(1, 1, 1, co);
      chk("prio_values", {8'd0, dut_val()}, 32'h123456);
      chk("prio_running", {31'd0, running}, 32'd0);
      chk("prio_overflow", {31'd0, overflow}, 32'd0);

      // asynchronous reset between edges while running
      set_digits(init_v, 24'h000123);
      cyc(0, 0, 1, co);
      cyc(0, 1, 0, co);
      cyc(0, 0, 0, co);
      chk("pre_async_values", {8'd0, dut_val()}, 32'h000123);
      #1 rst_n = 1'b0;
      #1;
      chk("async_values", {8'd0, dut_val()}, 32'd0);
      chk("async_running", {31'd0, running}, 32'd0);
      chk("async_overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized run, expectations pushed to the scoreboard
      for (int i = 0; i < 6; i++) m_val[i] = 0;
      m_run = 0;
      m_ovf = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n == 0 || $urandom_range(0, 99) < 2) begin
            for (int i = 0; i < 6; i++)
               lim_v[i] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2))
                                                       : 4'($urandom_range(3, 15));
         end
         for (int i = 0; i < 6; i++) init_v[i] = 4'($urandom_range(0, 15));
         t = ($urandom_range(0, 99) < 70);
         s = ($urandom_range(0, 99) < 8);
         l = (n == 0) || ($urandom_range(0, 99) < 3);
         tick = t; start_stop = s; load = l;
         e.co  = model_step(t, s, l);
         e.val = model_val();
         e.run = m_run;
         e.ovf = m_ovf;
         exp_q.push_back(e);
      end
      @(negedge clk);
      tick = 0; start_stop = 0; load = 0;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
